pzvip_stream_rx_packet_buffer: RTL and testbench
================================================

Name: pzvip_stream_rx_packet_buffer

Overview:
- Synthesizable store-and-forward packet buffer for the pzvip stream protocol (valid/ready/data/byte_enable/last).
- Slave (receive) port accepts beats from an upstream master and stores them in a FIFO.
- Master (transmit) port forwards a packet only once its last beat is stored.
- Packets longer than the FIFO would otherwise deadlock, so the block falls back to cut-through mode for those.

Parameters:
- DATA_WIDTH, 32, stream data width in bits; multiple of 8, at most PZVIP_STREAM_MAX_DATA_WIDTH.
- DEPTH, 16, FIFO depth in beats; power of 2, at least 2.
- PKT_CNT_WIDTH, 8, width of the stored-complete-packet counter; must hold DEPTH.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_valid  input  1  receive beat valid
- o_ready  output  1  receive ready
- i_data  input  DATA_WIDTH  receive data
- i_byte_enable  input  DATA_WIDTH/8  receive byte enables
- i_last  input  1  receive last beat of packet
- o_valid  output  1  transmit beat valid
- i_ready  input  1  transmit ready
- o_data  output  DATA_WIDTH  transmit data
- o_byte_enable  output  DATA_WIDTH/8  transmit byte enables
- o_last  output  1  transmit last beat
- o_level  output  $clog2(DEPTH+1)  beats currently stored
- o_cut_through  output  1  high while in CUT_THROUGH state

Behaviour:
- One clock; synchronous active-high reset on i_clk with i_rst.
- Reset clears pointers, level, packet count, and state (to STORE). Reset values: o_ready=1, o_valid=0, o_level=0, o_cut_through=0. o_data, o_byte_enable and o_last are don't-care while o_valid=0.
- Push occurs when i_valid && o_ready; it stores {data, byte_enable, last}.
- Pop occurs when o_valid && i_ready.
- o_ready = (o_level != DEPTH). There is no same-cycle pass-through when full, so a pop on a full cycle frees space on the next cycle.
- Packet counter:
  - +1 on a push with i_last=1; -1 on a pop with o_last=1.
  - Both in the same cycle leave it unchanged.
  - It never underflows or overflows, because a last beat counted in cannot exceed DEPTH.
- o_data, o_byte_enable and o_last come from the FIFO head (registered storage).
- Latency: a push of a last beat at edge N makes o_valid=1 from cycle N+1 (STORE state, FIFO previously empty). Minimum in-to-out latency is 1 cycle.
- State STORE: o_valid = (packet count > 0).
- STORE -> CUT_THROUGH: when level == DEPTH and packet count == 0 (FIFO full of a single incomplete packet).
- State CUT_THROUGH: o_valid = (level > 0). Ready still follows the full rule.
- CUT_THROUGH -> STORE: on the pop of a beat with o_last=1 that belongs to the oversized packet.
  - Track this with a flag that is set when the transition occurs.
  - Later complete packets behind it are counted normally. The pop of the oversized packet's last beat does not decrement the counter, because its push incremented it only if that last beat was pushed; implement the count so that this is consistent.
- o_level wraps nowhere: it is 0..DEPTH inclusive, pointers are $clog2(DEPTH)+1 bits, and full/empty are detected by the MSB compare.
- Once o_valid is asserted, o_valid and head data are held stable until the pop (protocol stability rule).
- Reset asserted mid-packet discards all stored beats. Upstream is expected to be reset in the same cycle.
- A packet of exactly DEPTH beats completes in STORE with no transition: the last beat makes the count 1 on the same edge that makes the FIFO full.

Optional Feature:
- Macro: PZVIP_STREAM_RX_PACKET_BUFFER_STATS_EN.
- Defined: adds output ports o_rx_packets[31:0], o_tx_packets[31:0] and o_cut_through_events[15:0].
  - Each is incremented on the push of a last beat, the pop of a last beat, and the STORE->CUT_THROUGH transition, respectively.
  - Each wraps modulo 2^width and is cleared by i_rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- 3-beat packet (data 0x11, 0x22, 0x33; byte_enable 0xF; last on beat 3), i_ready=1 -> o_valid stays 0 until the edge after beat 3 is pushed. Then 3 pops occur with identical data and o_last on the third; o_level goes 0->1->2->3->2->1->0.
- i_ready=0, push 16 single-beat packets -> o_level=16, o_ready=0, o_cut_through=0. Then i_ready=1 for 1 cycle -> o_ready=1 on the following cycle.
- 20-beat packet, DEPTH=16, i_ready=0 until full -> o_cut_through=1 once o_level=16 with count 0. With i_ready=1 all 20 beats drain in order, and o_cut_through=0 after the pop of beat 20.
- Continuous back-to-back 2-beat packets, i_valid=1 and i_ready=1 -> after first-packet latency, throughput is 1 beat/cycle, and the counter shows no drift: at idle, packet count is 0 and o_level=0.
- Reset asserted while 5 beats of a 7-beat packet are stored -> next cycle o_level=0, o_valid=0, o_ready=1. A following 2-beat packet is forwarded correctly.
- With STATS_EN: 4 normal packets plus 1 oversized packet -> o_rx_packets=5, o_tx_packets=5, o_cut_through_events=1.

Source files
------------

// File: rtl/pzvip_stream_rx_packet_buffer.sv
// Store-and-forward packet FIFO for the pzvip stream protocol with cut-through fallback.
// Define PZVIP_STREAM_RX_PACKET_BUFFER_STATS_EN to add packet/event statistics outputs.
module pzvip_stream_rx_packet_buffer #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned PKT_CNT_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic [DATA_WIDTH/8-1:0]    i_byte_enable,
  input  logic                       i_last,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic [DATA_WIDTH/8-1:0]    o_byte_enable,
  output logic                       o_last,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_cut_through
`ifdef PZVIP_STREAM_RX_PACKET_BUFFER_STATS_EN
  ,
  output logic [31:0]                o_rx_packets,
  output logic [31:0]                o_tx_packets,
  output logic [15:0]                o_cut_through_events
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = DATA_WIDTH / 8;
  localparam int unsigned EW = DATA_WIDTH + BW + 1;

  typedef enum logic {StStore, StCutThrough} state_e;

  logic [EW-1:0]            mem_q [DEPTH];
  logic [AW:0]              wptr_q;
  logic [AW:0]              rptr_q;
  logic [AW:0]              level;
  logic [PKT_CNT_WIDTH-1:0] pkt_cnt_q;
  logic [PKT_CNT_WIDTH-1:0] pkt_cnt_d;
  state_e                   state_q;
  logic                     oversize_rx_q;
  logic                     full;
  logic                     push;
  logic                     pop;
  logic                     push_count;
  logic                     pop_count;
  logic                     enter_cut;
  logic [EW-1:0]            head;

  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level = wptr_q - rptr_q;
  assign head  = mem_q[rptr_q[AW-1:0]];

  assign o_ready       = !full;
  assign o_level       = level;
  assign o_cut_through = (state_q == StCutThrough);
  assign o_valid       = (state_q == StStore) ? (pkt_cnt_q != '0) : (level != '0);
  assign o_data        = head[DATA_WIDTH-1:0];
  assign o_byte_enable = head[DATA_WIDTH+:BW];
  assign o_last        = head[EW-1];

  assign push      = i_valid && o_ready;
  assign pop       = o_valid && i_ready;
  assign enter_cut = (state_q == StStore) && full && (pkt_cnt_q == '0);

  // The oversized packet is never counted: neither its last push nor its last pop touch the count.
  assign push_count = push && i_last && !oversize_rx_q;
  assign pop_count  = pop && o_last && (state_q == StStore);

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (push_count && !pop_count) begin
      pkt_cnt_d = pkt_cnt_q + PKT_CNT_WIDTH'(1);
    end else if (!push_count && pop_count) begin
      pkt_cnt_d = pkt_cnt_q - PKT_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= {i_last, i_byte_enable, i_data};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      pkt_cnt_q     <= '0;
      state_q       <= StStore;
      oversize_rx_q <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + (AW+1)'(1);
      end
      pkt_cnt_q <= pkt_cnt_d;
      // A full FIFO blocks pushes, so entering cut-through never coincides with a push.
      if (enter_cut) begin
        oversize_rx_q <= 1'b1;
      end else if (push && i_last) begin
        oversize_rx_q <= 1'b0;
      end
      case (state_q)
        StStore: begin
          if (enter_cut) begin
            state_q <= StCutThrough;
          end
        end
        StCutThrough: begin
          if (pop && o_last) begin
            state_q <= StStore;
          end
        end
        default: state_q <= StStore;
      endcase
    end
  end

`ifdef PZVIP_STREAM_RX_PACKET_BUFFER_STATS_EN
  logic [31:0] rx_packets_q;
  logic [31:0] tx_packets_q;
  logic [15:0] cut_events_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_packets_q <= '0;
      tx_packets_q <= '0;
      cut_events_q <= '0;
    end else begin
      if (push && i_last) begin
        rx_packets_q <= rx_packets_q + 32'd1;
      end
      if (pop && o_last) begin
        tx_packets_q <= tx_packets_q + 32'd1;
      end
      if (enter_cut) begin
        cut_events_q <= cut_events_q + 16'd1;
      end
    end
  end

  assign o_rx_packets         = rx_packets_q;
  assign o_tx_packets         = tx_packets_q;
  assign o_cut_through_events = cut_events_q;
`endif

endmodule

// File: tb/tb_pzvip_stream_rx_packet_buffer.sv
// Bench for pzvip_stream_rx_packet_buffer: directed vector table, hand sequences and random
// traffic checked against a queue-based model of the packet buffer.
module tb_pzvip_stream_rx_packet_buffer;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  be;
    logic        l;
  } beat_t;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        r;
    int          lvl;
    logic        vld;
    logic [31:0] od;
    logic        ol;
  } vec_t;

  logic        clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic [3:0]  i_byte_enable;
  logic        i_last;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic [3:0]  o_byte_enable;
  logic        o_last;
  logic [4:0]  o_level;
  logic        o_cut_through;
`ifdef PZVIP_STREAM_RX_PACKET_BUFFER_STATS_EN
  logic [31:0] o_rx_packets;
  logic [31:0] o_tx_packets;
  logic [15:0] o_cut_through_events;
`endif

  pzvip_stream_rx_packet_buffer #(
    .DATA_WIDTH   (32),
    .DEPTH        (DEPTH),
    .PKT_CNT_WIDTH(8)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .i_byte_enable(i_byte_enable),
    .i_last       (i_last),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_byte_enable(o_byte_enable),
    .o_last       (o_last),
    .o_level      (o_level),
    .o_cut_through(o_cut_through)
`ifdef PZVIP_STREAM_RX_PACKET_BUFFER_STATS_EN
    ,
    .o_rx_packets        (o_rx_packets),
    .o_tx_packets        (o_tx_packets),
    .o_cut_through_events(o_cut_through_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;

  // Model: contents of the buffer as a queue, plus the cut-through flag.
  beat_t mq[$];
  beat_t src[$];
  bit    mcut;
  int    rx_m, tx_m, ev_m;

  bit    p_push, p_pop, p_enter, dut_pop;
  beat_t p_beat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit has_last();
    foreach (mq[i]) if (mq[i].l) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    mq.delete();
    src.delete();
    mcut = 1'b0;
    rx_m = 0;
    tx_m = 0;
    ev_m = 0;
  endtask

  task automatic drive_cycle(input logic v, input beat_t b, input logic r);
    bit exp_ready, exp_valid;
    @(negedge clk);
    i_valid       = v;
    i_data        = b.d;
    i_byte_enable = b.be;
    i_last        = b.l;
    i_ready       = r;
    exp_ready = (mq.size() != DEPTH);
    exp_valid = mcut ? (mq.size() > 0) : has_last();
    chk("ready", 64'(o_ready), 64'(exp_ready));
    chk("valid", 64'(o_valid), 64'(exp_valid));
    chk("level", 64'(o_level), 64'(mq.size()));
    chk("cut_through", 64'(o_cut_through), 64'(mcut));
    if (exp_valid && o_valid) begin
      chk("data", 64'(o_data), 64'(mq[0].d));
      chk("byte_enable", 64'(o_byte_enable), 64'(mq[0].be));
      chk("last", 64'(o_last), 64'(mq[0].l));
    end
    p_push  = v && exp_ready;
    p_pop   = exp_valid && r;
    p_beat  = b;
    p_enter = !mcut && (mq.size() == DEPTH) && !has_last();
    dut_pop = o_valid && r;
  endtask

  task automatic finish_cycle();
    beat_t h;
    @(posedge clk);
    if (p_pop) begin
      h = mq.pop_front();
      if (h.l) begin
        tx_m++;
        if (mcut) mcut = 1'b0;
      end
    end
    if (p_push) begin
      mq.push_back(p_beat);
      if (p_beat.l) rx_m++;
    end
    if (p_enter) begin
      mcut = 1'b1;
      ev_m++;
    end
  endtask

  task automatic drive_src(input bit ven, input bit r);
    beat_t b;
    b = (src.size() > 0) ? src[0] : '0;
    drive_cycle(ven && (src.size() > 0), b, r);
  endtask

  task automatic finish_src();
    finish_cycle();
    if (p_push) void'(src.pop_front());
  endtask

  task automatic cyc(input bit ven, input bit r);
    drive_src(ven, r);
    finish_src();
  endtask

  task automatic add_pkt(input int len, input logic [31:0] base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d  = base + 32'(k);
      b.be = 4'($urandom_range(15));
      b.l  = (k == len - 1);
      src.push_back(b);
    end
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((src.size() > 0 || mq.size() > 0) && n < maxc) begin
      cyc(1'b1, 1'b1);
      n++;
    end
    chk("drain_done", 64'(src.size() == 0 && mq.size() == 0), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    model_clear();
  endtask

  vec_t tbl[7];

  initial begin
    int pops, pops_win, rp;
    beat_t b;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_data = '0; i_byte_enable = '0; i_last = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;

    // 3-beat packet: nothing visible until the last beat is stored, then 3 pops.
    tbl[0] = '{1'b1, 32'h11, 1'b0, 1'b1, 0, 1'b0, 32'h0,  1'b0};
    tbl[1] = '{1'b1, 32'h22, 1'b0, 1'b1, 1, 1'b0, 32'h0,  1'b0};
    tbl[2] = '{1'b1, 32'h33, 1'b1, 1'b1, 2, 1'b0, 32'h0,  1'b0};
    tbl[3] = '{1'b0, 32'h0,  1'b0, 1'b1, 3, 1'b1, 32'h11, 1'b0};
    tbl[4] = '{1'b0, 32'h0,  1'b0, 1'b1, 2, 1'b1, 32'h22, 1'b0};
    tbl[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 1, 1'b1, 32'h33, 1'b1};
    tbl[6] = '{1'b0, 32'h0,  1'b0, 1'b1, 0, 1'b0, 32'h0,  1'b0};
    for (int i = 0; i < 7; i++) begin
      b.d  = tbl[i].d;
      b.be = 4'hF;
      b.l  = tbl[i].l;
      drive_cycle(tbl[i].v, b, tbl[i].r);
      chk($sformatf("tbl%0d_level", i), 64'(o_level), 64'(tbl[i].lvl));
      chk($sformatf("tbl%0d_valid", i), 64'(o_valid), 64'(tbl[i].vld));
      chk($sformatf("tbl%0d_ready", i), 64'(o_ready), 64'd1);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_data", i), 64'(o_data), 64'(tbl[i].od));
        chk($sformatf("tbl%0d_last", i), 64'(o_last), 64'(tbl[i].ol));
      end
      finish_cycle();
    end

    // 16 single-beat packets fill the FIFO without entering cut-through.
    for (int k = 0; k < DEPTH; k++) add_pkt(1, 32'h100 + 32'(k));
    for (int k = 0; k < DEPTH; k++) cyc(1'b1, 1'b0);
    drive_src(1'b0, 1'b0);
    chk("full_level", 64'(o_level), 64'd16);
    chk("full_ready", 64'(o_ready), 64'd0);
    chk("full_cut", 64'(o_cut_through), 64'd0);
    finish_src();
    drive_src(1'b0, 1'b1);
    chk("full_pop_ready", 64'(o_ready), 64'd0);
    finish_src();
    drive_src(1'b0, 1'b0);
    chk("after_pop_ready", 64'(o_ready), 64'd1);
    chk("after_pop_level", 64'(o_level), 64'd15);
    finish_src();
    drain(100);

    // 20-beat packet overflows the FIFO and forces cut-through.
    add_pkt(20, 32'h200);
    for (int k = 0; k < DEPTH; k++) cyc(1'b1, 1'b0);
    drive_src(1'b1, 1'b0);
    chk("ovf_level", 64'(o_level), 64'd16);
    chk("ovf_cut_pre", 64'(o_cut_through), 64'd0);
    finish_src();
    drive_src(1'b1, 1'b0);
    chk("ovf_cut", 64'(o_cut_through), 64'd1);
    chk("ovf_valid", 64'(o_valid), 64'd1);
    finish_src();
    drain(100);
    drive_src(1'b0, 1'b0);
    chk("ovf_cut_exit", 64'(o_cut_through), 64'd0);
    finish_src();

    // Back-to-back 2-beat packets sustain one beat per cycle.
    for (int k = 0; k < 20; k++) add_pkt(2, 32'h300 + 32'(2 * k));
    pops = 0;
    pops_win = 0;
    for (int c = 0; c < 42; c++) begin
      drive_src(1'b1, 1'b1);
      if (dut_pop) begin
        pops++;
        if (c >= 2 && c < 40) pops_win++;
      end
      finish_src();
    end
    chk("tput_window", 64'(pops_win), 64'd38);
    chk("tput_total", 64'(pops), 64'd40);
    drive_src(1'b0, 1'b0);
    chk("idle_level", 64'(o_level), 64'd0);
    chk("idle_valid", 64'(o_valid), 64'd0);
    finish_src();

    // Reset with 5 beats of a 7-beat packet stored.
    add_pkt(7, 32'h400);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0);
    do_reset();
    drive_src(1'b0, 1'b0);
    chk("rst_level", 64'(o_level), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_cut", 64'(o_cut_through), 64'd0);
    finish_src();
    add_pkt(2, 32'h500);
    drain(20);

    // Statistics: 4 normal packets plus one oversized packet.
    do_reset();
    for (int k = 0; k < 4; k++) add_pkt(2, 32'h600 + 32'(4 * k));
    drain(40);
    add_pkt(20, 32'h700);
    for (int k = 0; k < DEPTH + 1; k++) cyc(1'b1, 1'b0);
    drain(100);
`ifdef PZVIP_STREAM_RX_PACKET_BUFFER_STATS_EN
    drive_src(1'b0, 1'b0);
    chk("stats_rx", 64'(o_rx_packets), 64'd5);
    chk("stats_tx", 64'(o_tx_packets), 64'd5);
    chk("stats_cut", 64'(o_cut_through_events), 64'd1);
    finish_src();
`endif

    // Random traffic with alternating light and heavy backpressure.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rp = ((c / 500) % 2 == 0) ? 80 : 15;
      if (src.size() == 0) add_pkt(int'($urandom_range(1, 24)), $urandom);
      cyc($urandom_range(99) < 70, $urandom_range(99) < rp);
    end
    drain(500);
`ifdef PZVIP_STREAM_RX_PACKET_BUFFER_STATS_EN
    drive_src(1'b0, 1'b0);
    chk("rand_rx", 64'(o_rx_packets), 64'(rx_m));
    chk("rand_tx", 64'(o_tx_packets), 64'(tx_m));
    chk("rand_cut", 64'(o_cut_through_events), 64'(ev_m));
    finish_src();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
